spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_arbiter.sv | 173 +++++++++++++++++
 tb/tb_spi_arbiter.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester round-robin arbiter for one SPI byte engine; SPI_ARB_TIMEOUT_EN adds owner-inactivity timeout with lockout
module spi_arbiter #(
    parameter int SS_GAP         = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_req,
    output logic       req0_gnt,
    input  logic       req0_tx_valid,
    input  logic [7:0] req0_tx_data,
    output logic       req0_tx_ready,
    output logic       req0_rx_valid,
    output logic [7:0] req0_rx_data,
    input  logic       req0_rx_ready,
    input  logic       req1_req,
    output logic       req1_gnt,
    input  logic       req1_tx_valid,
    input  logic [7:0] req1_tx_data,
    output logic       req1_tx_ready,
    output logic       req1_rx_valid,
    output logic [7:0] req1_rx_data,
    input  logic       req1_rx_ready,
    output logic       spi_tx_valid,
    output logic [7:0] spi_tx_data,
    input  logic       spi_tx_ready,
    input  logic       spi_rx_valid,
    input  logic [7:0] spi_rx_data,
    output logic       spi_rx_ready,
    output logic       spi_ss,
    output logic       busy,
    output logic       timeout
);
    typedef enum logic [2:0] {S_IDLE, S_OWN0, S_OWN1, S_DRAIN, S_GAP} state_t;

    state_t     r_state;
    logic [1:0] r_pending;
    logic [7:0] r_gap_cnt;
    logic       r_last;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_ss;
    logic       r_busy;
    logic       w_own0;
    logic       w_own1;
    logic       w_drain;
    logic       w_full;
    logic       w_tx_hs;
    logic       w_rx_hs;
    logic       w_el0;
    logic       w_el1;
    logic       w_to_hit;

    assign w_own0   = (r_state == S_OWN0);
    assign w_own1   = (r_state == S_OWN1);
    assign w_drain  = (r_state == S_DRAIN);
    assign w_full   = (r_pending == 2'd3);
    assign w_tx_hs  = spi_tx_valid & spi_tx_ready;
    assign w_rx_hs  = spi_rx_valid & spi_rx_ready;
    assign req0_gnt = r_gnt0;
    assign req1_gnt = r_gnt1;
    assign spi_ss   = r_ss;
    assign busy     = r_busy;

    // route byte streams to the owner; late drain bytes go to the last owner and are never back-pressured
    always_comb begin
        spi_tx_valid  = ~w_full & ((w_own0 & req0_tx_valid) | (w_own1 & req1_tx_valid));
        spi_tx_data   = w_own1 ? req1_tx_data : w_own0 ? req0_tx_data : 8'h00;
        req0_tx_ready = w_own0 & spi_tx_ready & ~w_full;
        req1_tx_ready = w_own1 & spi_tx_ready & ~w_full;
        spi_rx_ready  = w_own0 ? req0_rx_ready : w_own1 ? req1_rx_ready : 1'b1;
        req0_rx_valid = spi_rx_valid & (w_own0 | (w_drain & ~r_last));
        req1_rx_valid = spi_rx_valid & (w_own1 | (w_drain & r_last));
        req0_rx_data  = spi_rx_data;
        req1_rx_data  = spi_rx_data;
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic [1:0]  r_lock;
    logic        r_timeout;

    assign w_el0    = req0_req & ~r_lock[0];
    assign w_el1    = req1_req & ~r_lock[1];
    assign w_to_hit = ((w_own0 & req0_req) | (w_own1 & req1_req)) & ~(w_tx_hs | w_rx_hs)
                      & (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign timeout  = r_timeout;

    // count owner inactivity; on expiry pulse timeout and lock the owner out until it drops req
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt  <= 16'd0;
            r_lock    <= 2'b00;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= ((w_own0 | w_own1) & ~(w_tx_hs | w_rx_hs)) ? r_to_cnt + 16'd1 : 16'd0;
            r_timeout <= w_to_hit;
            r_lock[0] <= (r_lock[0] & req0_req) | (w_own0 & w_to_hit);
            r_lock[1] <= (r_lock[1] & req1_req) | (w_own1 & w_to_hit);
        end
    end
`else
    logic w_unused_timeout;

    assign w_el0            = req0_req;
    assign w_el1            = req1_req;
    assign w_to_hit         = 1'b0;
    assign timeout          = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // ownership FSM with registered grant/select/busy and the in-flight byte counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pending <= 2'd0;
            r_gap_cnt <= 8'd0;
            r_last    <= 1'b1;
            r_gnt0    <= 1'b0;
            r_gnt1    <= 1'b0;
            r_ss      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_pending <= r_pending + {1'b0, w_tx_hs & ~w_rx_hs}
                         - {1'b0, w_rx_hs & ~w_tx_hs & (r_pending != 2'd0)};
            case (r_state)
                S_IDLE: begin
                    if (w_el0 & (~w_el1 | r_last)) begin
                        r_state <= S_OWN0;
                        r_gnt0  <= 1'b1;
                        r_last  <= 1'b0;
                        r_ss    <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (w_el1) begin
                        r_state <= S_OWN1;
                        r_gnt1  <= 1'b1;
                        r_last  <= 1'b1;
                        r_ss    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_OWN0: begin
                    if (~req0_req | w_to_hit) begin
                        r_state <= S_DRAIN;
                        r_gnt0  <= 1'b0;
                    end
                end
                S_OWN1: begin
                    if (~req1_req | w_to_hit) begin
                        r_state <= S_DRAIN;
                        r_gnt1  <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_pending == 2'd0) begin
                        r_state   <= S_GAP;
                        r_ss      <= 1'b1;
                        r_gap_cnt <= 8'd0;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == 8'(SS_GAP - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scenario bench for spi_arbiter with an rx-byte scoreboard
module tb_spi_arbiter;
    localparam int SS_GAP = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_req = 1'b0, req1_req = 1'b0;
    logic       req0_gnt, req1_gnt;
    logic       req0_tx_valid = 1'b0, req1_tx_valid = 1'b0;
    logic [7:0] req0_tx_data = 8'h00, req1_tx_data = 8'h00;
    logic       req0_tx_ready, req1_tx_ready;
    logic       req0_rx_valid, req1_rx_valid;
    logic [7:0] req0_rx_data, req1_rx_data;
    logic       req0_rx_ready = 1'b1, req1_rx_ready = 1'b1;
    logic       spi_tx_valid;
    logic [7:0] spi_tx_data;
    logic       spi_tx_ready = 1'b0;
    logic       spi_rx_valid = 1'b0;
    logic [7:0] spi_rx_data = 8'h00;
    logic       spi_rx_ready;
    logic       spi_ss, busy, timeout;

    int total = 0;
    int bad = 0;
    logic [8:0] exp_q[$];

    spi_arbiter #(.SS_GAP(SS_GAP), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .req0_req(req0_req), .req0_gnt(req0_gnt),
        .req0_tx_valid(req0_tx_valid), .req0_tx_data(req0_tx_data), .req0_tx_ready(req0_tx_ready),
        .req0_rx_valid(req0_rx_valid), .req0_rx_data(req0_rx_data), .req0_rx_ready(req0_rx_ready),
        .req1_req(req1_req), .req1_gnt(req1_gnt),
        .req1_tx_valid(req1_tx_valid), .req1_tx_data(req1_tx_data), .req1_tx_ready(req1_tx_ready),
        .req1_rx_valid(req1_rx_valid), .req1_rx_data(req1_rx_data), .req1_rx_ready(req1_rx_ready),
        .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data), .spi_tx_ready(spi_tx_ready),
        .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data), .spi_rx_ready(spi_rx_ready),
        .spi_ss(spi_ss), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
    endtask

    task set_req(input int o, input logic v);
        if (o == 0) req0_req = v;
        else req1_req = v;
    endtask

    task set_tx(input int o, input logic v, input logic [7:0] d);
        if (o == 0) begin
            req0_tx_valid = v;
            req0_tx_data = d;
        end else begin
            req1_tx_valid = v;
            req1_tx_data = d;
        end
    endtask

    task send_byte(input int o, input logic [7:0] d);
        set_tx(o, 1'b1, d);
        spi_tx_ready = 1'b1;
        tick;
        set_tx(o, 1'b0, 8'h00);
    endtask

    task return_byte(input int o, input logic [7:0] d);
        exp_q.push_back({1'(o), d});
        spi_rx_valid = 1'b1;
        spi_rx_data = d;
        tick;
        spi_rx_valid = 1'b0;
    endtask

    task test_reset;
        req0_tx_valid = 1'b1;
        spi_tx_ready = 1'b1;
        tick;
        tick;
        total++;
        if ({req0_gnt, req1_gnt, spi_tx_valid, busy, timeout} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000", {req0_gnt, req1_gnt, spi_tx_valid, busy, timeout});
        end
        total++;
        if ({spi_ss, spi_rx_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_ss_rxrdy got=%b want=11", {spi_ss, spi_rx_ready});
        end
        total++;
        if ({req0_tx_ready, req1_tx_ready, req0_rx_valid, req1_rx_valid} !== 4'b0) begin
            bad++;
            $display("FAIL reset_streams got=%b want=0000", {req0_tx_ready, req1_tx_ready, req0_rx_valid, req1_rx_valid});
        end
        req0_tx_valid = 1'b0;
        spi_tx_ready = 1'b0;
    endtask

    task test_tie;
        reset = 1'b0;
        req0_req = 1'b1;
        req1_req = 1'b1;
        tick;
        total++;
        if ({req0_gnt, req1_gnt, spi_ss, busy} !== 4'b1001) begin
            bad++;
            $display("FAIL tie_grant got=%b want=1001", {req0_gnt, req1_gnt, spi_ss, busy});
        end
        repeat (3) tick;
        total++;
        if ({req0_gnt, req1_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL tie_hold got=%b want=10", {req0_gnt, req1_gnt});
        end
        req1_req = 1'b0;
    endtask

    task test_drain;
        int n;
        set_tx(0, 1'b1, 8'hA5);
        spi_tx_ready = 1'b1;
        #1;
        total++;
        if ({spi_tx_valid, spi_tx_data, req0_tx_ready, req1_tx_ready} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL tx_pass got=%b_%h_%b%b want=1_a5_10", spi_tx_valid, spi_tx_data, req0_tx_ready, req1_tx_ready);
        end
        tick;
        send_byte(0, 8'h3C);
        spi_tx_ready = 1'b0;
        req0_req = 1'b0;
        tick;
        total++;
        if ({req0_gnt, spi_ss, busy, spi_tx_valid} !== 4'b0010) begin
            bad++;
            $display("FAIL drain_enter got=%b want=0010", {req0_gnt, spi_ss, busy, spi_tx_valid});
        end
        req1_req = 1'b1;
        req0_rx_ready = 1'b1;
        return_byte(0, 8'h11);
        total++;
        if (spi_ss !== 1'b0) begin
            bad++;
            $display("FAIL drain_ss_pend1 got=%b want=0", spi_ss);
        end
        return_byte(0, 8'h22);
        total++;
        if (spi_ss !== 1'b0) begin
            bad++;
            $display("FAIL drain_ss_pend0 got=%b want=0", spi_ss);
        end
        tick;
        total++;
        if ({spi_ss, req1_gnt} !== 2'b10) begin
            bad++;
            $display("FAIL gap_enter got=%b want=10", {spi_ss, req1_gnt});
        end
        n = 0;
        while (!req1_gnt && n < 30) begin
            tick;
            n++;
        end
        total++;
        if (n != SS_GAP + 1 || req1_gnt !== 1'b1) begin
            bad++;
            $display("FAIL regrant_latency got=%0d gnt1=%b want=%0d gnt1=1", n, req1_gnt, SS_GAP + 1);
        end
    endtask

    task test_back_to_back;
        int o, nxt, n, hi;
        logic g_nxt, g_o;
        req0_req = 1'b1;
        o = 1;
        for (int i = 0; i < 4; i++) begin
            send_byte(o, 8'h40 + 8'(i));
            spi_tx_ready = 1'b0;
            return_byte(o, 8'h80 + 8'(i));
            set_req(o, 1'b0);
            tick;
            set_req(o, 1'b1);
            n = 0;
            hi = 0;
            while (!(req0_gnt | req1_gnt) && n < 30) begin
                tick;
                n++;
                if (spi_ss) hi++;
            end
            nxt = 1 - o;
            g_nxt = (nxt == 0) ? req0_gnt : req1_gnt;
            g_o = (o == 0) ? req0_gnt : req1_gnt;
            total++;
            if ({g_nxt, g_o} !== 2'b10) begin
                bad++;
                $display("FAIL alt_grant step=%0d got=%b%b want=10 (owner %0d)", i, g_nxt, g_o, nxt);
            end
            total++;
            if (hi < SS_GAP) begin
                bad++;
                $display("FAIL alt_gap step=%0d got=%0d want>=%0d", i, hi, SS_GAP);
            end
            o = nxt;
        end
        req0_req = 1'b0;
    endtask

    task test_saturate;
        spi_tx_ready = 1'b0;
        set_tx(1, 1'b1, 8'h55);
        #1;
        total++;
        if ({req1_tx_ready, spi_tx_valid} !== 2'b01) begin
            bad++;
            $display("FAIL stall_ready got=%b want=01", {req1_tx_ready, spi_tx_valid});
        end
        tick;
        tick;
        spi_tx_ready = 1'b1;
        #1;
        total++;
        if (req1_tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL unstall_ready got=%b want=1", req1_tx_ready);
        end
        repeat (3) tick;
        total++;
        if ({req1_tx_ready, spi_tx_valid} !== 2'b00) begin
            bad++;
            $display("FAIL sat_block got=%b want=00", {req1_tx_ready, spi_tx_valid});
        end
        tick;
        tick;
        total++;
        if ({req1_tx_ready, spi_tx_valid} !== 2'b00) begin
            bad++;
            $display("FAIL sat_hold got=%b want=00", {req1_tx_ready, spi_tx_valid});
        end
        return_byte(1, 8'hC1);
        #1;
        total++;
        if (req1_tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL sat_release got=%b want=1", req1_tx_ready);
        end
        set_tx(1, 1'b0, 8'h00);
        spi_tx_ready = 1'b0;
        return_byte(1, 8'hC2);
        return_byte(1, 8'hC3);
    endtask

    task test_reset_mid;
        int hs, n;
        send_byte(1, 8'h77);
        spi_tx_ready = 1'b0;
        reset = 1'b1;
        req1_req = 1'b0;
        tick;
        reset = 1'b0;
        total++;
        if ({spi_ss, req1_gnt, busy} !== 3'b100) begin
            bad++;
            $display("FAIL abort got=%b want=100", {spi_ss, req1_gnt, busy});
        end
        spi_rx_valid = 1'b1;
        spi_rx_data = 8'hEE;
        #1;
        total++;
        if ({spi_rx_ready, req0_rx_valid, req1_rx_valid} !== 3'b100) begin
            bad++;
            $display("FAIL late_discard got=%b want=100", {spi_rx_ready, req0_rx_valid, req1_rx_valid});
        end
        tick;
        spi_rx_valid = 1'b0;
        req1_req = 1'b1;
        n = 0;
        while (!req1_gnt && n < 10) begin
            tick;
            n++;
        end
        set_tx(1, 1'b1, 8'h99);
        spi_tx_ready = 1'b1;
        #1;
        hs = 0;
        repeat (5) begin
            if (req1_tx_ready) hs++;
            tick;
        end
        total++;
        if (hs != 3 || req1_gnt !== 1'b1) begin
            bad++;
            $display("FAIL pend_cleared got=%0d gnt1=%b want=3 gnt1=1", hs, req1_gnt);
        end
        set_tx(1, 1'b0, 8'h00);
        spi_tx_ready = 1'b0;
        return_byte(1, 8'hD1);
        return_byte(1, 8'hD2);
        return_byte(1, 8'hD3);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task test_timeout;
        int n, g;
        req1_req = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            tick;
            n++;
        end
        req1_req = 1'b1;
        n = 0;
        while (!req1_gnt && n < 10) begin
            tick;
            n++;
        end
        n = 0;
        while (!timeout && n < 40) begin
            tick;
            n++;
        end
        total++;
        if (n != 16 || req1_gnt !== 1'b0) begin
            bad++;
            $display("FAIL to_fire got=%0d gnt1=%b want=16 gnt1=0", n, req1_gnt);
        end
        tick;
        total++;
        if (timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_pulse got=%b want=0", timeout);
        end
        g = 0;
        repeat (20) begin
            tick;
            if (req1_gnt) g++;
        end
        total++;
        if (g != 0) begin
            bad++;
            $display("FAIL lockout got=%0d want=0", g);
        end
        req1_req = 1'b0;
        tick;
        req1_req = 1'b1;
        n = 0;
        while (!req1_gnt && n < 30) begin
            tick;
            n++;
        end
        total++;
        if (req1_gnt !== 1'b1) begin
            bad++;
            $display("FAIL unlock got=%b want=1", req1_gnt);
        end
    endtask
`else
    task test_timeout;
        int lost, fired;
        lost = 0;
        fired = 0;
        repeat (40) begin
            tick;
            if (!req1_gnt) lost++;
            if (timeout) fired++;
        end
        total++;
        if (lost != 0) begin
            bad++;
            $display("FAIL hold_forever got=%0d want=0", lost);
        end
        total++;
        if (fired != 0) begin
            bad++;
            $display("FAIL timeout_tied got=%0d want=0", fired);
        end
    endtask
`endif

    initial begin
        fork
            forever begin
                logic [8:0] got, want;
                @(negedge clk);
                if (!reset) begin
                    for (int k = 0; k < 2; k++) begin
                        if (k == 0 ? (req0_rx_valid & req0_rx_ready) : (req1_rx_valid & req1_rx_ready)) begin
                            got = (k == 0) ? {1'b0, req0_rx_data} : {1'b1, req1_rx_data};
                            total++;
                            if (exp_q.size() == 0) begin
                                bad++;
                                $display("FAIL rx_unexpected got=%h want=none", got);
                            end else begin
                                want = exp_q.pop_front();
                                if (got !== want) begin
                                    bad++;
                                    $display("FAIL rx_data got=%h want=%h", got, want);
                                end
                            end
                        end
                    end
                end
            end
        join_none
        test_reset;
        test_tie;
        test_drain;
        test_back_to_back;
        test_saturate;
        test_reset_mid;
        test_timeout;
        tick;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL rx_missing got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
